// File: rtl/filter_oper_scheduler.sv
// Filter-select front end: per-button sync + debounce, lowest-index arbitration and
// deferred commit of the filter code. Define FRAME_SYNC_EN to hold commits until frame_start.

module filter_oper_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    logic [1:0]       sync_q;
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The count must already equal DEBOUNCE_CYCLES while the mismatch persists,
    // so the level change lands in cycle 2+DEBOUNCE_CYCLES after the raw edge.
    always_comb begin
        deb_d   = deb_q;
        cnt_d   = '0;
        press_o = 1'b0;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                deb_d   = sync_q[1];
                press_o = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            deb_q  <= deb_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

module filter_oper_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] button,
    input  logic       frame_start,
    output logic [7:0] oper,
    output logic       oper_load,
    output logic       pending
);
    localparam int NUM_BTN = 8;

    typedef enum logic {S_IDLE, S_PEND} state_e;

    logic [NUM_BTN-1:0] press;
    logic               any_press;
    logic [2:0]         win_idx;
    logic [7:0]         cand_code, req_code;
    logic               commit;
    state_e             state_q;
    logic [7:0]         code_q, oper_q;
    logic               load_q;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        filter_oper_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (button[g]),
            .press_o(press[g])
        );
    end

    always_comb begin
        win_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (press[i]) win_idx = 3'(i);
        end
    end

    assign any_press = |press;
    assign cand_code = 8'h31 + {5'd0, win_idx};
    // Re-selecting the committed filter toggles back to pass-through.
    assign req_code  = (cand_code == oper_q) ? 8'h00 : cand_code;

`ifdef FRAME_SYNC_EN
    assign commit = frame_start;
`else
    // frame_start has no effect here; commit the cycle after entering PENDING.
    assign commit = 1'b1 | frame_start;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            code_q  <= '0;
            oper_q  <= '0;
            load_q  <= 1'b0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (any_press) begin
                        code_q  <= req_code;
                        state_q <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (commit) begin
                        oper_q  <= any_press ? req_code : code_q;
                        load_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (any_press) begin
                        code_q <= req_code;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign oper      = oper_q;
    assign oper_load = load_q;
    assign pending   = (state_q == S_PEND);
endmodule
